// File: rtl/processor.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, 32x32 register file, ALU,
// data RAM and decode. The ROM image is placed by the environment before reset release.
module processor #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned IAW  = $clog2(IMEM_WORDS);
  localparam int unsigned DAW  = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  typedef enum logic [1:0] {PC_SEQ, PC_REL, PC_JALR} pc_sel_e;

  logic [XLEN-1:0] imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] rf   [NREG];
  logic [XLEN-1:0] pc;

  logic [IAW-1:0]  imem_idx;
  logic [DAW-1:0]  dmem_idx;
  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs_eq;
  logic            rs_lt;

  logic            rf_we;
  logic            dmem_we;
  logic            dmem_we_c;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  pc_sel_e         pc_sel;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] dmem_rdata;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;

  // Fetch with wrap over the ROM depth
  assign imem_idx = IAW'(pc[31:2] % 30'(IMEM_WORDS));
  assign instr    = imem[imem_idx];

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Asynchronous register reads; x0 is hard-wired to zero
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign rs_eq   = (rs1_val == rs2_val);
  assign rs_lt   = ($signed(rs1_val) < $signed(rs2_val));

  // Decode; anything unrecognised falls through as a NOP
  always_comb begin
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    use_imm = 1'b0;
    imm     = imm_i;
    alu_op  = ALU_ADD;
    wb_sel  = WB_ALU;
    pc_sel  = PC_SEQ;
    case (opcode)
      OP_LUI: begin
        rf_we  = 1'b1;
        wb_sel = WB_IMM;
        imm    = imm_u;
      end
      OP_JAL: begin
        rf_we  = 1'b1;
        wb_sel = WB_PC4;
        imm    = imm_j;
        pc_sel = PC_REL;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we   = 1'b1;
          wb_sel  = WB_PC4;
          use_imm = 1'b1;
          pc_sel  = PC_JALR;
        end
      end
      OP_BRANCH: begin
        imm = imm_b;
        case (funct3)
          3'b000:  if (rs_eq)  pc_sel = PC_REL;
          3'b001:  if (!rs_eq) pc_sel = PC_REL;
          3'b100:  if (rs_lt)  pc_sel = PC_REL;
          3'b101:  if (!rs_lt) pc_sel = PC_REL;
          default: pc_sel = PC_SEQ;
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we   = 1'b1;
          use_imm = 1'b1;
          wb_sel  = WB_MEM;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dmem_we = 1'b1;
          use_imm = 1'b1;
          imm     = imm_s;
        end
      end
      OP_IMM: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) alu_op = ALU_SLL;
            else                   rf_we  = 1'b0;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       rf_we  = 1'b0;
          end
          default: rf_we = 1'b0;
        endcase
      end
      OP_REG: begin
        rf_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: alu_op = ALU_SUB;
          {F7_BASE, 3'b001}: alu_op = ALU_SLL;
          {F7_BASE, 3'b010}: alu_op = ALU_SLT;
          {F7_BASE, 3'b011}: alu_op = ALU_SLTU;
          {F7_BASE, 3'b100}: alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: alu_op = ALU_SRA;
          {F7_BASE, 3'b110}: alu_op = ALU_OR;
          {F7_BASE, 3'b111}: alu_op = ALU_AND;
          default:           rf_we  = 1'b0;
        endcase
      end
      default: rf_we = 1'b0;
    endcase
  end

  assign alu_a = rs1_val;
  assign alu_b = use_imm ? imm : rs2_val;
  assign shamt = alu_b[4:0];

  // ALU: wrapping two's-complement arithmetic, 5-bit shift amounts
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // Word-addressed data RAM; low address bits dropped, index wraps
  assign dmem_idx   = DAW'(alu_res[31:2] % 30'(DMEM_WORDS));
  assign dmem_rdata = dmem[dmem_idx];
  assign dmem_we_c  = dmem_we & reset;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm;
      default: wb_data = alu_res;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    case (pc_sel)
      PC_REL:  pc_next = pc + imm;
      PC_JALR: pc_next = {alu_res[31:1], 1'b0};
      default: pc_next = pc_plus4;
    endcase
  end

  // Architectural state: PC and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rf_we && (rd != 5'd0)) rf[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we_c) dmem[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_processor.sv
// Directed-program bench for the single-cycle core; programs are placed in the ROM
// hierarchically and results read back through pc, rf[] and dmem[].
module tb_processor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  processor #(
    .IMEM_WORDS(256),
    .DMEM_WORDS(256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] op_i(logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] op_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] op_lw(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] op_sw(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] op_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] op_jal(logic [4:0] rd, logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] op_jalr(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] op_lui(logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter reset and blank the ROM (all-zero words execute as NOPs)
  task automatic start_load();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    dut.imem[0] = op_i(3'b000, 5'd1, 5'd0, 12'd5);
    step(3);
    checks++;
    if (dut.pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h0);
    end
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (dut.rf[i] !== 32'h0) begin
        errors++; $display("FAIL reset_rf x%0d: got %h expected %h", i, dut.rf[i], 32'h0);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dut.pc !== 32'h0) begin
      errors++; $display("FAIL release_pc0: got %h expected %h", dut.pc, 32'h0);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      checks++;
      if (dut.pc !== 32'(4 * k)) begin
        errors++; $display("FAIL release_pc_seq %0d: got %h expected %h", k, dut.pc, 32'(4 * k));
      end
    end
    checks++;
    if (dut.rf[1] !== 32'd5) begin
      errors++; $display("FAIL first_instr x1: got %h expected %h", dut.rf[1], 32'd5);
    end
  endtask

  task automatic test_alu();
    logic [31:0] prog [18];
    int unsigned r [18];
    logic [31:0] e [18];
    prog = '{
      op_i(3'b000, 5'd1, 5'd0, 12'd5),
      op_i(3'b000, 5'd2, 5'd0, 12'hFFD),
      op_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2),
      op_r(7'h20, 3'b000, 5'd4, 5'd1, 5'd2),
      op_r(7'h00, 3'b111, 5'd5, 5'd1, 5'd2),
      op_r(7'h00, 3'b110, 5'd6, 5'd1, 5'd2),
      op_r(7'h00, 3'b100, 5'd7, 5'd1, 5'd2),
      op_r(7'h00, 3'b010, 5'd8, 5'd2, 5'd1),
      op_r(7'h00, 3'b011, 5'd9, 5'd2, 5'd1),
      op_r(7'h00, 3'b001, 5'd10, 5'd1, 5'd1),
      op_r(7'h00, 3'b101, 5'd11, 5'd2, 5'd1),
      op_i(3'b111, 5'd12, 5'd2, 12'h0F0),
      op_i(3'b110, 5'd13, 5'd1, 12'h100),
      op_i(3'b100, 5'd14, 5'd1, 12'hFFF),
      op_i(3'b010, 5'd15, 5'd2, 12'hFFE),
      op_i(3'b001, 5'd16, 5'd1, 12'h004),
      op_i(3'b101, 5'd17, 5'd2, 12'h01C),
      op_lui(5'd18, 20'h12345)
    };
    r = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};
    e = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF8,
          32'd1, 32'd0, 32'hA0, 32'h07FF_FFFF, 32'hF0, 32'h105, 32'hFFFF_FFFA,
          32'd1, 32'h50, 32'hF, 32'h1234_5000};
    start_load();
    for (int i = 0; i < 18; i++) dut.imem[i] = prog[i];
    release_reset();
    step(18);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (dut.rf[r[i]] !== e[i]) begin
        errors++; $display("FAIL alu x%0d: got %h expected %h", r[i], dut.rf[r[i]], e[i]);
      end
    end
    checks++;
    if (dut.pc !== 32'h48) begin
      errors++; $display("FAIL alu_pc: got %h expected %h", dut.pc, 32'h48);
    end
  endtask

  task automatic test_memory();
    start_load();
    dut.imem[0] = op_i(3'b000, 5'd1, 5'd0, 12'h055);
    dut.imem[1] = op_sw(5'd1, 5'd0, 12'd8);
    dut.imem[2] = op_lw(5'd5, 5'd0, 12'd8);
    dut.imem[3] = op_i(3'b000, 5'd9, 5'd0, 12'h066);
    dut.imem[4] = op_sw(5'd9, 5'd0, 12'd4);
    dut.imem[5] = op_i(3'b000, 5'd10, 5'd0, 12'h077);
    dut.imem[6] = op_sw(5'd10, 5'd0, 12'h404);
    dut.imem[7] = op_lw(5'd7, 5'd0, 12'd4);
    dut.imem[8] = op_lw(5'd8, 5'd0, 12'd10);
    release_reset();
    step(9);
    checks++;
    if (dut.dmem[2] !== 32'h55) begin
      errors++; $display("FAIL sw_dmem2: got %h expected %h", dut.dmem[2], 32'h55);
    end
    checks++;
    if (dut.rf[5] !== 32'h55) begin
      errors++; $display("FAIL lw_x5: got %h expected %h", dut.rf[5], 32'h55);
    end
    checks++;
    if (dut.dmem[1] !== 32'h77) begin
      errors++; $display("FAIL sw_wrap_dmem1: got %h expected %h", dut.dmem[1], 32'h77);
    end
    checks++;
    if (dut.rf[7] !== 32'h77) begin
      errors++; $display("FAIL lw_wrap_x7: got %h expected %h", dut.rf[7], 32'h77);
    end
    checks++;
    if (dut.rf[8] !== 32'h55) begin
      errors++; $display("FAIL lw_lowbits_x8: got %h expected %h", dut.rf[8], 32'h55);
    end
    checks++;
    if (dut.pc !== 32'h24) begin
      errors++; $display("FAIL mem_pc: got %h expected %h", dut.pc, 32'h24);
    end
  endtask

  task automatic test_branch();
    int unsigned r [9];
    logic [31:0] e [9];
    start_load();
    dut.imem[0]  = op_i(3'b000, 5'd1, 5'd0, 12'd3);
    dut.imem[1]  = op_i(3'b000, 5'd1, 5'd1, 12'hFFF);
    dut.imem[2]  = op_i(3'b000, 5'd3, 5'd3, 12'd1);
    dut.imem[3]  = op_b(3'b001, 5'd1, 5'd0, 13'h1FF8);
    dut.imem[4]  = op_b(3'b000, 5'd1, 5'd0, 13'd8);
    dut.imem[5]  = op_i(3'b000, 5'd4, 5'd0, 12'd1);
    dut.imem[6]  = op_b(3'b000, 5'd3, 5'd0, 13'd8);
    dut.imem[7]  = op_i(3'b000, 5'd5, 5'd0, 12'd7);
    dut.imem[8]  = op_i(3'b000, 5'd6, 5'd0, 12'hFFF);
    dut.imem[9]  = op_b(3'b100, 5'd6, 5'd0, 13'd8);
    dut.imem[10] = op_i(3'b000, 5'd7, 5'd0, 12'd1);
    dut.imem[11] = op_b(3'b101, 5'd6, 5'd0, 13'd8);
    dut.imem[12] = op_i(3'b000, 5'd8, 5'd0, 12'd9);
    dut.imem[13] = op_b(3'b101, 5'd0, 5'd6, 13'd8);
    dut.imem[14] = op_i(3'b000, 5'd9, 5'd0, 12'd1);
    dut.imem[15] = op_i(3'b000, 5'd10, 5'd0, 12'd2);
    release_reset();
    step(4);
    checks++;
    if (dut.pc !== 32'h4) begin
      errors++; $display("FAIL bne_taken_pc: got %h expected %h", dut.pc, 32'h4);
    end
    step(15);
    r = '{1, 3, 4, 5, 6, 7, 8, 9, 10};
    e = '{32'd0, 32'd3, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'd0, 32'd2};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut.rf[r[i]] !== e[i]) begin
        errors++; $display("FAIL branch x%0d: got %h expected %h", r[i], dut.rf[r[i]], e[i]);
      end
    end
    checks++;
    if (dut.pc !== 32'h40) begin
      errors++; $display("FAIL branch_pc: got %h expected %h", dut.pc, 32'h40);
    end
  endtask

  task automatic test_jump();
    start_load();
    dut.imem[0]  = op_i(3'b000, 5'd6, 5'd6, 12'd1);
    dut.imem[4]  = op_jal(5'd1, 21'd12);
    dut.imem[5]  = op_i(3'b000, 5'd3, 5'd0, 12'h031);
    dut.imem[6]  = op_jalr(5'd4, 5'd3, 12'd0);
    dut.imem[7]  = op_jalr(5'd0, 5'd1, 12'd0);
    dut.imem[12] = op_i(3'b000, 5'd5, 5'd0, 12'h400);
    dut.imem[13] = op_jalr(5'd0, 5'd5, 12'd0);
    release_reset();
    step(5);
    checks++;
    if (dut.pc !== 32'h1C) begin
      errors++; $display("FAIL jal_pc: got %h expected %h", dut.pc, 32'h1C);
    end
    checks++;
    if (dut.rf[1] !== 32'h14) begin
      errors++; $display("FAIL jal_link: got %h expected %h", dut.rf[1], 32'h14);
    end
    step(1);
    checks++;
    if (dut.pc !== 32'h14) begin
      errors++; $display("FAIL jalr_pc: got %h expected %h", dut.pc, 32'h14);
    end
    step(2);
    checks++;
    if (dut.pc !== 32'h30) begin
      errors++; $display("FAIL jalr_odd_pc: got %h expected %h", dut.pc, 32'h30);
    end
    checks++;
    if (dut.rf[4] !== 32'h1C) begin
      errors++; $display("FAIL jalr_link: got %h expected %h", dut.rf[4], 32'h1C);
    end
    step(2);
    checks++;
    if (dut.pc !== 32'h400) begin
      errors++; $display("FAIL wrap_target_pc: got %h expected %h", dut.pc, 32'h400);
    end
    step(1);
    checks++;
    if (dut.pc !== 32'h404) begin
      errors++; $display("FAIL wrap_pc: got %h expected %h", dut.pc, 32'h404);
    end
    checks++;
    if (dut.rf[6] !== 32'd2) begin
      errors++; $display("FAIL wrap_fetch x6: got %h expected %h", dut.rf[6], 32'd2);
    end
  endtask

  task automatic test_misc_and_midreset();
    start_load();
    dut.imem[0] = op_i(3'b000, 5'd0, 5'd0, 12'd7);
    dut.imem[1] = op_lui(5'd1, 20'h80000);
    dut.imem[2] = op_i(3'b101, 5'd2, 5'd1, 12'h404);
    dut.imem[3] = op_i(3'b000, 5'd3, 5'd0, 12'd4);
    dut.imem[4] = op_r(7'h20, 3'b101, 5'd4, 5'd1, 5'd3);
    dut.imem[5] = 32'hFFFF_FFFF;
    dut.imem[6] = 32'h0000_0000;
    dut.imem[7] = op_i(3'b000, 5'd5, 5'd0, 12'd1);
    dut.imem[8] = op_i(3'b000, 5'd6, 5'd0, 12'd2);
    release_reset();
    step(8);
    checks++;
    if (dut.rf[0] !== 32'h0) begin
      errors++; $display("FAIL x0_write: got %h expected %h", dut.rf[0], 32'h0);
    end
    checks++;
    if (dut.rf[2] !== 32'hF800_0000) begin
      errors++; $display("FAIL srai: got %h expected %h", dut.rf[2], 32'hF800_0000);
    end
    checks++;
    if (dut.rf[4] !== 32'hF800_0000) begin
      errors++; $display("FAIL sra: got %h expected %h", dut.rf[4], 32'hF800_0000);
    end
    checks++;
    if (dut.rf[5] !== 32'd1) begin
      errors++; $display("FAIL illegal_nop x5: got %h expected %h", dut.rf[5], 32'd1);
    end
    checks++;
    if (dut.pc !== 32'h20) begin
      errors++; $display("FAIL illegal_nop_pc: got %h expected %h", dut.pc, 32'h20);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 32'h0) begin
      errors++; $display("FAIL midreset_pc: got %h expected %h", dut.pc, 32'h0);
    end
    @(negedge clk);
    checks++;
    if (dut.rf[6] !== 32'h0) begin
      errors++; $display("FAIL midreset_discard x6: got %h expected %h", dut.rf[6], 32'h0);
    end
    checks++;
    if (dut.rf[5] !== 32'h0) begin
      errors++; $display("FAIL midreset_clear x5: got %h expected %h", dut.rf[5], 32'h0);
    end
    reset = 1'b1;
    step(2);
    checks++;
    if (dut.pc !== 32'h8) begin
      errors++; $display("FAIL restart_pc: got %h expected %h", dut.pc, 32'h8);
    end
    checks++;
    if (dut.rf[1] !== 32'h8000_0000) begin
      errors++; $display("FAIL restart_lui: got %h expected %h", dut.rf[1], 32'h8000_0000);
    end
    step(7);
    checks++;
    if (dut.rf[6] !== 32'd2) begin
      errors++; $display("FAIL restart_end x6: got %h expected %h", dut.rf[6], 32'd2);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_jump();
    test_misc_and_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
